laser_job_sequencer: RTL and testbench



---
 rtl/laser_job_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_laser_job_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/laser_job_sequencer.sv
// Job front-end for the 40-point two-circle laser solver: buffer points, kick and stream the solver, return its result.
// Optional WAIT watchdog enabled by defining LASER_SEQ_TIMEOUT_EN.
module laser_job_sequencer #(
  parameter int unsigned N_POINTS = 40,
  parameter int unsigned PTR_W    = 6
`ifdef LASER_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 8191
`endif
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [3:0] IN_X,
  input  logic [3:0] IN_Y,
  output logic       SOL_RST,
  output logic [3:0] SOL_X,
  output logic [3:0] SOL_Y,
  input  logic       SOL_DONE,
  input  logic [3:0] SOL_C1X,
  input  logic [3:0] SOL_C1Y,
  input  logic [3:0] SOL_C2X,
  input  logic [3:0] SOL_C2Y,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [3:0] OUT_C1X,
  output logic [3:0] OUT_C1Y,
  output logic [3:0] OUT_C2X,
  output logic [3:0] OUT_C2Y,
  output logic       OUT_ERR,
  output logic [7:0] JOB_CNT
);

  localparam int unsigned PT_W  = 8;
  localparam int unsigned RES_W = 16;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_LOAD,
    S_KICK,
    S_STREAM,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   job_cnt_q, job_cnt_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [PT_W-1:0]    sol_pt_q, sol_pt_d;
  logic               in_ready_q;
  logic               sol_rst_q;
  logic               out_valid_q;
  logic               in_hs_c;
  logic               out_hs_c;
  logic [PT_W-1:0]    mem_q [N_POINTS];

`ifdef LASER_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
`endif

  assign in_hs_c  = IN_VALID && in_ready_q && (state_q == S_LOAD);
  assign out_hs_c = out_valid_q && OUT_READY && (state_q == S_RESULT);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    job_cnt_d = job_cnt_q;
    res_d     = res_q;
    sol_pt_d  = '0;
`ifdef LASER_SEQ_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (in_hs_c) begin
          if (wr_ptr_q == PTR_W'(N_POINTS - 1)) begin
            wr_ptr_d = '0;
            state_d  = S_KICK;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_KICK: begin
        rd_ptr_d = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        if (rd_ptr_q == PTR_W'(N_POINTS - 1)) begin
          rd_ptr_d = '0;
          state_d  = S_WAIT;
`ifdef LASER_SEQ_TIMEOUT_EN
          wd_d     = '0;
`endif
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (SOL_DONE) begin
          res_d   = {SOL_C1X, SOL_C1Y, SOL_C2X, SOL_C2Y};
          state_d = S_RESULT;
`ifdef LASER_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESULT;
        end else begin
          wd_d    = wd_q + 1'b1;
`endif
        end
      end
      S_RESULT: begin
        if (out_hs_c) begin
          job_cnt_d = job_cnt_q + 8'd1;
          state_d   = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
    // Points are presented from the pointer the solver will see next cycle, so streaming has no bubbles
    if (state_d == S_STREAM) begin
      sol_pt_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      job_cnt_q   <= '0;
      res_q       <= '0;
      sol_pt_q    <= '0;
      in_ready_q  <= 1'b0;
      sol_rst_q   <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef LASER_SEQ_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      job_cnt_q   <= job_cnt_d;
      res_q       <= res_d;
      sol_pt_q    <= sol_pt_d;
      in_ready_q  <= (state_d == S_LOAD);
      sol_rst_q   <= (state_d == S_KICK);
      out_valid_q <= (state_d == S_RESULT);
`ifdef LASER_SEQ_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  // Point buffer; contents are don't-care until written by a load
  always_ff @(posedge CLK) begin
    if (in_hs_c) begin
      mem_q[wr_ptr_q] <= {IN_X, IN_Y};
    end
  end

  assign IN_READY  = in_ready_q;
  assign SOL_RST   = sol_rst_q;
  assign SOL_X     = sol_pt_q[7:4];
  assign SOL_Y     = sol_pt_q[3:0];
  assign OUT_VALID = out_valid_q;
  assign OUT_C1X   = res_q[15:12];
  assign OUT_C1Y   = res_q[11:8];
  assign OUT_C2X   = res_q[7:4];
  assign OUT_C2Y   = res_q[3:0];
  assign JOB_CNT   = job_cnt_q;
`ifdef LASER_SEQ_TIMEOUT_EN
  assign OUT_ERR   = err_q;
`else
  assign OUT_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_laser_job_sequencer.sv
// Directed bench for laser_job_sequencer: load, kick, stream, result handshake, abort and watchdog.
module tb_laser_job_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] IN_X, IN_Y;
  logic       SOL_RST;
  logic [3:0] SOL_X, SOL_Y;
  logic       SOL_DONE;
  logic [3:0] SOL_C1X, SOL_C1Y, SOL_C2X, SOL_C2Y;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [3:0] OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y;
  logic       OUT_ERR;
  logic [7:0] JOB_CNT;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] pts [40];

`ifdef LASER_SEQ_TIMEOUT_EN
  laser_job_sequencer #(.N_POINTS(40), .PTR_W(6), .TIMEOUT_CYCLES(100)) dut (
`else
  laser_job_sequencer #(.N_POINTS(40), .PTR_W(6)) dut (
`endif
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_X(IN_X), .IN_Y(IN_Y),
    .SOL_RST(SOL_RST), .SOL_X(SOL_X), .SOL_Y(SOL_Y), .SOL_DONE(SOL_DONE),
    .SOL_C1X(SOL_C1X), .SOL_C1Y(SOL_C1Y), .SOL_C2X(SOL_C2X), .SOL_C2Y(SOL_C2Y),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_C1X(OUT_C1X), .OUT_C1Y(OUT_C1Y), .OUT_C2X(OUT_C2X), .OUT_C2Y(OUT_C2Y),
    .OUT_ERR(OUT_ERR), .JOB_CNT(JOB_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; IN_VALID = 1'b0; IN_X = '0; IN_Y = '0; SOL_DONE = 1'b0;
    SOL_C1X = '0; SOL_C1Y = '0; SOL_C2X = '0; SOL_C2Y = '0; OUT_READY = 1'b0;
    step(); step();
    n_checks++;
    if ({IN_READY, SOL_RST, OUT_VALID, OUT_ERR} !== 4'b0100)
      $display("FAIL reset_ctrl: got rdy/rst/vld/err=%b expected 0100", {IN_READY, SOL_RST, OUT_VALID, OUT_ERR});
    else n_pass++;
    n_checks++;
    if ({JOB_CNT, SOL_X, SOL_Y, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y} !== 32'h0)
      $display("FAIL reset_data: got %h expected 0", {JOB_CNT, SOL_X, SOL_Y, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y});
    else n_pass++;
    RST_N = 1'b1;
    step();
    n_checks++;
    if ({IN_READY, SOL_RST} !== 2'b10)
      $display("FAIL reset_release: got rdy/rst=%b expected 10", {IN_READY, SOL_RST});
    else n_pass++;
  endtask

  // Load all 40 pts; gap=1 toggles IN_VALID; SOL_DONE pulsed on cycle done_at
  task automatic load_points(input int gap, input int done_at, input string tag);
    int k = 0;
    int cyc = 0;
    bit hs;
    bit early = 0;
    bit spurious = 0;
    while (k < 40 && cyc < 400) begin
      IN_VALID = (gap == 0) || (cyc % 2 == 0);
      IN_X = pts[k][7:4];
      IN_Y = pts[k][3:0];
      SOL_DONE = (cyc == done_at);
      SOL_C1X = 4'hF; SOL_C1Y = 4'hE; SOL_C2X = 4'hD; SOL_C2Y = 4'hC;
      hs = IN_VALID && IN_READY;
      if (SOL_RST) early = 1;
      if (OUT_VALID) spurious = 1;
      step();
      cyc++;
      if (hs) k++;
    end
    IN_VALID = 1'b0; SOL_DONE = 1'b0;
    n_checks++;
    if (k != 40) $display("FAIL %s_count: got %0d handshakes expected 40", tag, k); else n_pass++;
    n_checks++;
    if (early || spurious) $display("FAIL %s_early: got early_kick=%0d out_valid=%0d expected 0 0", tag, early, spurious); else n_pass++;
    n_checks++;
    if ({IN_READY, SOL_RST} !== 2'b01)
      $display("FAIL %s_kick: got rdy/rst=%b expected 01", tag, {IN_READY, SOL_RST});
    else n_pass++;
  endtask

  task automatic stream_check(input int done_at, input string tag);
    int bad_idx = -1;
    bit ctrl_bad = 0;
    step();
    for (int i = 0; i < 40; i++) begin
      if ({SOL_X, SOL_Y} !== pts[i] && bad_idx < 0) bad_idx = i;
      if (SOL_RST !== 1'b0 || IN_READY !== 1'b0 || OUT_VALID !== 1'b0) ctrl_bad = 1;
      SOL_DONE = (i == done_at);
      step();
    end
    SOL_DONE = 1'b0;
    n_checks++;
    if (bad_idx >= 0)
      $display("FAIL %s_order: point %0d got %h expected %h", tag, bad_idx, {SOL_X, SOL_Y}, pts[bad_idx]);
    else n_pass++;
    n_checks++;
    if (ctrl_bad) $display("FAIL %s_ctrl: got bad rst/rdy/vld during stream expected 0/0/0", tag); else n_pass++;
    n_checks++;
    if ({SOL_X, SOL_Y, SOL_RST, OUT_VALID} !== 10'b0)
      $display("FAIL %s_after: got sol=%h rst=%b vld=%b expected 00 0 0", tag, {SOL_X, SOL_Y}, SOL_RST, OUT_VALID);
    else n_pass++;
  endtask

  task automatic finish_job(input logic [15:0] exp, input int hold, input logic [7:0] exp_cnt, input string tag);
    bit bad = 0;
    step(); step();
    n_checks++;
    if (OUT_VALID !== 1'b0) $display("FAIL %s_wait: got out_valid=%b expected 0", tag, OUT_VALID); else n_pass++;
    SOL_DONE = 1'b1;
    {SOL_C1X, SOL_C1Y, SOL_C2X, SOL_C2Y} = exp;
    OUT_READY = (hold == 0);
    step();
    SOL_DONE = 1'b0;
    {SOL_C1X, SOL_C1Y, SOL_C2X, SOL_C2Y} = 16'h0;
    for (int h = 0; h < hold; h++) begin
      if (OUT_VALID !== 1'b1 || {OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y} !== exp || OUT_ERR !== 1'b0 || IN_READY !== 1'b0)
        bad = 1;
      step();
    end
    n_checks++;
    if (bad) $display("FAIL %s_hold: result not stable over %0d held cycles, expected %h", tag, hold, exp); else n_pass++;
    n_checks++;
    if ({OUT_VALID, OUT_ERR, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y} !== {2'b10, exp})
      $display("FAIL %s_result: got vld/err=%b res=%h expected 10 %h", tag, {OUT_VALID, OUT_ERR}, {OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y}, exp);
    else n_pass++;
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    n_checks++;
    if ({OUT_VALID, IN_READY} !== 2'b01 || JOB_CNT !== exp_cnt)
      $display("FAIL %s_consume: got vld/rdy=%b cnt=%0d expected 01 %0d", tag, {OUT_VALID, IN_READY}, JOB_CNT, exp_cnt);
    else n_pass++;
    n_checks++;
    if ({OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y} !== exp)
      $display("FAIL %s_keep: got %h expected %h", tag, {OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y}, exp);
    else n_pass++;
  endtask

  task automatic test_continuous_load();
    for (int i = 0; i < 40; i++) pts[i] = 8'(i * 37 + 5);
    load_points(0, -1, "cont");
    stream_check(-1, "cont");
    finish_job(16'h35B9, 5, 8'd1, "cont");
  endtask

  task automatic test_gapped_load();
    for (int i = 0; i < 40; i++) pts[i] = 8'((i * 11) ^ 8'h5A);
    load_points(1, 7, "gap");
    stream_check(10, "gap");
    finish_job(16'hA1C7, 0, 8'd2, "gap");
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 20; i++) begin
      IN_VALID = 1'b1; IN_X = 4'(i); IN_Y = 4'hA;
      step();
    end
    #2;
    RST_N = 1'b0;
    #1;
    IN_VALID = 1'b0;
    n_checks++;
    if ({SOL_RST, IN_READY, OUT_VALID} !== 3'b100 || JOB_CNT !== 8'd0)
      $display("FAIL abort_reset: got rst/rdy/vld=%b cnt=%0d expected 100 0", {SOL_RST, IN_READY, OUT_VALID}, JOB_CNT);
    else n_pass++;
    step(); step();
    RST_N = 1'b1;
    step();
    n_checks++;
    if ({IN_READY, SOL_RST} !== 2'b10)
      $display("FAIL abort_release: got rdy/rst=%b expected 10", {IN_READY, SOL_RST});
    else n_pass++;
    for (int i = 0; i < 40; i++) pts[i] = 8'(255 - i * 3);
    load_points(0, -1, "abort");
    stream_check(-1, "abort");
    finish_job(16'h0F60, 1, 8'd1, "abort");
  endtask

  task automatic test_timeout();
    bit early = 0;
    for (int i = 0; i < 40; i++) pts[i] = 8'(i * 3 + 100);
    load_points(0, -1, "wd");
    stream_check(-1, "wd");
`ifdef LASER_SEQ_TIMEOUT_EN
    for (int c = 0; c < 99; c++) begin
      if (OUT_VALID !== 1'b0) early = 1;
      step();
    end
    n_checks++;
    if (early || OUT_VALID !== 1'b0) $display("FAIL wd_early: out_valid rose before 100 wait cycles, expected 0"); else n_pass++;
    step();
    n_checks++;
    if ({OUT_VALID, OUT_ERR, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y} !== 18'b11_0000_0000_0000_0000)
      $display("FAIL wd_expire: got vld/err=%b res=%h expected 11 0000", {OUT_VALID, OUT_ERR}, {OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y});
    else n_pass++;
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    n_checks++;
    if ({OUT_VALID, IN_READY} !== 2'b01 || JOB_CNT !== 8'd2)
      $display("FAIL wd_consume: got vld/rdy=%b cnt=%0d expected 01 2", {OUT_VALID, IN_READY}, JOB_CNT);
    else n_pass++;
`else
    for (int c = 0; c < 150; c++) begin
      if (OUT_VALID !== 1'b0 || OUT_ERR !== 1'b0 || IN_READY !== 1'b0) early = 1;
      step();
    end
    n_checks++;
    if (early) $display("FAIL wd_none: got out_valid/err/in_ready while waiting, expected 0"); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_continuous_load();
    test_gapped_load();
    test_reset_abort();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
